mem_controller: RTL and testbench

- Memory-side responder for the CPU core's request/response port.
- Accepts one word read or write at a time from the core and services it from an internal word-addressed RAM after a fixed, parameterised latency.
- Returns completion through a one-cycle mem_response pulse.
- Also models slow memory, so the core's stall and handshake logic can be exercised.

---
 rtl/mem_controller.sv | 101 ++++++++++
 tb/tb_mem_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Word-addressed RAM responder for the core's request/response port.
// Each accepted request completes after LATENCY edges with a one-cycle response pulse.
module mem_controller #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_val,
  output logic [31:0] mem_read_val,
  output logic        mem_response,
  output logic        mem_error
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int DEPTH = 2 ** ADDR_BITS;

  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_index;
  logic                   r_fault;
  logic                   r_write;
  logic [31:0]            r_wdata;
  logic [31:0]            r_readVal;
  logic                   r_response;
  logic                   r_error;
  logic [31:0]            r_mem [0:DEPTH-1];

  logic                   w_access;
  logic                   w_ramWe;
  logic                   w_unused;

  // Byte-offset bits never select anything; the word index ignores them.
  assign w_unused = &{1'b0, mem_addr[1:0]};

  assign w_access = (r_state == BUSY) && (r_cnt == 8'd0);
  assign w_ramWe  = w_access && r_write && !r_fault;

  // Request/latency/response sequencing; everything used by the access is latched at sample time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_index    <= '0;
      r_fault    <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= 32'd0;
      r_readVal  <= 32'd0;
      r_response <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_read_en || mem_write_en) begin
            r_index <= mem_addr[ADDR_BITS+1:2];
            r_fault <= |mem_addr[31:ADDR_BITS+2];
            r_write <= mem_write_en;
            r_wdata <= mem_write_val;
            r_cnt   <= 8'(LATENCY - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            // Writes leave the read register alone; faulted reads return zero.
            if (!r_write) begin
              r_readVal <= r_fault ? 32'd0 : r_mem[r_index];
            end
            r_response <= 1'b1;
            r_error    <= r_fault;
            r_state    <= RESP;
          end
        end
        RESP: begin
          r_response <= 1'b0;
          r_error    <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset, so the array sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  assign mem_read_val = r_readVal;
  assign mem_response = r_response;
  assign mem_error    = r_error;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench: three controllers (LATENCY 3, 1, 8) driven from vector tables,
// with a scoreboard queue of expected responses popped when each response pulse appears.
module tb_mem_controller;

  logic        clk;
  logic        reset;
  logic [31:0] addr  [3];
  logic        rdEn  [3];
  logic        wrEn  [3];
  logic [31:0] wVal  [3];
  logic [31:0] rVal  [3];
  logic        resp  [3];
  logic        err   [3];

  int          lat   [3];
  int          cyc;
  int          lastResp [3];
  int          total;
  int          passed;

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expVal;
    bit          expErr;
  } vec_t;

  typedef struct {
    int          d;
    logic [31:0] expVal;
    bit          expErr;
  } exp_t;

  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : ((g == 1) ? 1 : 8);
    mem_controller #(.ADDR_BITS(10), .LATENCY(L)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_addr     (addr[g]),
      .mem_read_en  (rdEn[g]),
      .mem_write_en (wrEn[g]),
      .mem_write_val(wVal[g]),
      .mem_read_val (rVal[g]),
      .mem_response (resp[g]),
      .mem_error    (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency and throughput.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Drive one request, wait for its response, compare against the scoreboard entry.
  task automatic applyStimulus(input int d, input bit we, input bit re, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] expVal, input bit expErr,
                               input bit churn, input bit chkThru);
    int    n;
    int    sampleCyc;
    exp_t  e;
    @(negedge clk);
    wrEn[d] = we;
    rdEn[d] = re;
    addr[d] = a;
    wVal[d] = wd;
    sb.push_back('{d: d, expVal: expVal, expErr: expErr});
    @(posedge clk);
    #1;
    sampleCyc = cyc;
    if (churn) begin
      @(negedge clk);
      addr[d] = a ^ 32'h4;
      wVal[d] = ~wd;
    end
    n = 0;
    while (resp[d] !== 1'b1 && n < 300) begin
      if (n > 0 || churn) begin end
      @(posedge clk);
      #1;
      n = cyc - sampleCyc;
    end
    if (resp[d] !== 1'b1) begin
      total++;
      $display("[TB] FAIL timeout dut%0d: no response after %0d edges, expected %0d", d, n, lat[d]);
      void'(sb.pop_front());
      wrEn[d] = 1'b0;
      rdEn[d] = 1'b0;
      return;
    end
    checkOutput($sformatf("latency dut%0d", d), n, lat[d]);
    e = sb.pop_front();
    checkOutput($sformatf("readVal dut%0d @%08h", e.d, a), rVal[d], e.expVal);
    checkOutput($sformatf("error dut%0d @%08h", e.d, a), {31'd0, err[d]}, {31'd0, e.expErr});
    if (chkThru) checkOutput($sformatf("throughput dut%0d", d), cyc - lastResp[d], lat[d] + 2);
    lastResp[d] = cyc;
    @(negedge clk);
    wrEn[d] = 1'b0;
    rdEn[d] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput($sformatf("pulse width dut%0d", d), {31'd0, resp[d]}, 32'd0);
  endtask

  vec_t vecs[$];
  vec_t latVecs[$];

  initial begin
    lat[0] = 3; lat[1] = 1; lat[2] = 8;
    total = 0;
    passed = 0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 32'd0; rdEn[i] = 1'b0; wrEn[i] = 1'b0; wVal[i] = 32'd0; lastResp[i] = 0;
    end

    vecs = '{
      '{1, 0, 32'h10,   32'hDEADBEEF, 32'h00000000, 0},
      '{0, 1, 32'h10,   32'h0,        32'hDEADBEEF, 0},
      '{1, 0, 32'h0,    32'h11111111, 32'hDEADBEEF, 0},
      '{1, 0, 32'h1000, 32'h12345678, 32'hDEADBEEF, 1},
      '{0, 1, 32'h0,    32'h0,        32'h11111111, 0},
      '{0, 1, 32'h1000, 32'h0,        32'h00000000, 1},
      '{1, 1, 32'h20,   32'hA5A5A5A5, 32'h00000000, 0},
      '{0, 1, 32'h20,   32'h0,        32'hA5A5A5A5, 0},
      '{0, 1, 32'h13,   32'h0,        32'hDEADBEEF, 0},
      '{1, 0, 32'h30,   32'hCAFEF00D, 32'hDEADBEEF, 0},
      '{1, 0, 32'hFFC,  32'h0BADC0DE, 32'hDEADBEEF, 0},
      '{0, 1, 32'hFFC,  32'h0,        32'h0BADC0DE, 0},
      '{0, 1, 32'h30,   32'h0,        32'hCAFEF00D, 0},
      '{1, 0, 32'h44,   32'h44444444, 32'hCAFEF00D, 0}
    };

    latVecs = '{
      '{1, 0, 32'h8, 32'h01234567, 32'h00000000, 0},
      '{1, 0, 32'hC, 32'h89ABCDEF, 32'h00000000, 0},
      '{0, 1, 32'h8, 32'h0,        32'h01234567, 0},
      '{0, 1, 32'hC, 32'h0,        32'h89ABCDEF, 0}
    };

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset readVal dut%0d", i), rVal[i], 32'd0);
      checkOutput($sformatf("reset response dut%0d", i), {31'd0, resp[i]}, 32'd0);
      checkOutput($sformatf("reset error dut%0d", i), {31'd0, err[i]}, 32'd0);
    end

    // Latency sweep with back-to-back requests on the LATENCY=1 and LATENCY=8 instances.
    for (int d = 1; d < 3; d++) begin
      foreach (latVecs[i]) begin
        applyStimulus(d, latVecs[i].we, latVecs[i].re, latVecs[i].addr, latVecs[i].wdata,
                      latVecs[i].expVal, latVecs[i].expErr, 1'b0, i > 0);
      end
    end

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                    vecs[i].expVal, vecs[i].expErr, 1'b0, i > 0);
    end

    // Address and data change while BUSY; the latched request must win.
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h12121212, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h12121212, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h44444444, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a write to 0x30 is in flight.
    @(negedge clk);
    wrEn[0] = 1'b1;
    addr[0] = 32'h30;
    wVal[0] = 32'h77777777;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset readVal", rVal[0], 32'd0);
    checkOutput("midreset response", {31'd0, resp[0]}, 32'd0);
    checkOutput("midreset error", {31'd0, err[0]}, 32'd0);
    wrEn[0] = 1'b0;
    #1;
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (lat[0] + 4) begin
        @(posedge clk);
        #1;
        if (resp[0] === 1'b1) seen++;
      end
      checkOutput("no response after reset", seen, 0);
    end
    applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);

    checkOutput("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
